// File: rtl/cla_pipe.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// Define CLA_PIPE_SAT_EN to saturate the sum on two's-complement overflow.
module cla_pipe #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4,
    parameter int PIPE  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf
);

    localparam int NG = WIDTH / GROUP;

    // Flat sum-of-products carry into position hi given the carry into lo:
    // cin & P[lo..hi-1] | OR_i G[i] & P[i+1..hi-1]. Used at bit and group level.
    function automatic logic lookahead(
        input logic [WIDTH-1:0] gv,
        input logic [WIDTH-1:0] pv,
        input logic             cin,
        input int               lo,
        input int               hi
    );
        logic c;
        logic term;
        c = cin;
        for (int k = 0; k < WIDTH; k++) begin
            if (k >= lo && k < hi) c = c & pv[k];
        end
        for (int i = 0; i < WIDTH; i++) begin
            if (i >= lo && i < hi) begin
                term = gv[i];
                for (int k = 0; k < WIDTH; k++) begin
                    if (k > i && k < hi) term = term & pv[k];
                end
                c = c | term;
            end
        end
        return c;
    endfunction

    // Sums the groups [glo, ghi) from the stage carry-in; bits outside that
    // range are passed through from earlier stages. Returns {carry, sum}.
    function automatic logic [WIDTH:0] cla_stage(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y,
        input logic [WIDTH-1:0] s_prev,
        input logic             cin,
        input int               glo,
        input int               ghi
    );
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] gg;
        logic [WIDTH-1:0] gp;
        logic [WIDTH-1:0] sum;
        logic             gcin;
        logic             c;
        p   = x ^ y;
        g   = x & y;
        gg  = '0;
        gp  = '0;
        sum = s_prev;
        for (int j = 0; j < NG; j++) begin
            gg[j] = lookahead(g, p, 1'b0, j * GROUP, (j + 1) * GROUP);
            gp[j] = 1'b1;
            for (int m = 0; m < GROUP; m++) gp[j] = gp[j] & p[j*GROUP+m];
        end
        for (int j = 0; j < NG; j++) begin
            if (j >= glo && j < ghi) begin
                gcin = lookahead(gg, gp, cin, glo, j);
                for (int m = 0; m < GROUP; m++) begin
                    c = lookahead(g, p, gcin, j * GROUP, j * GROUP + m);
                    sum[j*GROUP+m] = p[j*GROUP+m] ^ c;
                end
            end
        end
        return {lookahead(gg, gp, cin, glo, ghi), sum};
    endfunction

    logic             en;
    logic [WIDTH-1:0] st_a [PIPE];
    logic [WIDTH-1:0] st_b [PIPE];
    logic [WIDTH-1:0] st_s [PIPE];
    logic             st_c [PIPE];
    logic             st_v [PIPE];

    logic             fin_v;
    logic             fin_c;
    logic             fin_sa;
    logic             fin_sb;
    logic [WIDTH-1:0] fin_s;
    logic             ovf_raw;

    assign en       = !fin_v || out_ready;
    assign in_ready = en;

    assign st_a[0] = a;
    assign st_b[0] = b ^ {WIDTH{sub}};
    assign st_s[0] = '0;
    assign st_c[0] = c_in ^ sub;
    assign st_v[0] = in_valid;

    for (genvar k = 0; k < PIPE; k++) begin : g_stage
        localparam int GLO = k * NG / PIPE;
        localparam int GHI = (k + 1) * NG / PIPE;

        logic [WIDTH:0]   res;
        logic             v_r;
        logic             c_r;
        logic             sa_r;
        logic             sb_r;
        logic [WIDTH-1:0] s_r;

        assign res = cla_stage(st_a[k], st_b[k], st_s[k], st_c[k], GLO, GHI);

        always_ff @(posedge clk) begin
            if (rst) begin
                v_r <= 1'b0;
            end else if (en) begin
                v_r <= st_v[k];
            end
        end

        // The partial sum, inter-stage carry and operand signs advance together.
        always_ff @(posedge clk) begin
            if (en) begin
                s_r  <= res[WIDTH-1:0];
                c_r  <= res[WIDTH];
                sa_r <= st_a[k][WIDTH-1];
                sb_r <= st_b[k][WIDTH-1];
            end
        end

        if (k < PIPE - 1) begin : g_fwd
            logic [WIDTH-1:0] a_r;
            logic [WIDTH-1:0] b_r;

            always_ff @(posedge clk) begin
                if (en) begin
                    a_r <= st_a[k];
                    b_r <= st_b[k];
                end
            end

            assign st_a[k+1] = a_r;
            assign st_b[k+1] = b_r;
            assign st_s[k+1] = s_r;
            assign st_c[k+1] = c_r;
            assign st_v[k+1] = v_r;
        end else begin : g_last
            assign fin_v  = v_r;
            assign fin_c  = c_r;
            assign fin_s  = s_r;
            assign fin_sa = sa_r;
            assign fin_sb = sb_r;
        end
    end

    assign ovf_raw = (fin_sa == fin_sb) && (fin_s[WIDTH-1] != fin_sa);

    // Outputs read as zero whenever no result is present.
    always_comb begin
        out_valid = fin_v;
        s         = '0;
        c_out     = 1'b0;
        ovf       = 1'b0;
        if (fin_v) begin
            c_out = fin_c;
            ovf   = ovf_raw;
`ifdef CLA_PIPE_SAT_EN
            if (ovf_raw) begin
                s = fin_sa ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
            end else begin
                s = fin_s;
            end
`else
            s = fin_s;
`endif
        end
    end

endmodule

// File: doc/cla_pipe.md
CLA_PIPE -- requirements
Module: cla_pipe

Interface
Parameters:
REQ-001 The block SHALL have parameter WIDTH, default 16: operand width in bits; legal values are multiples of GROUP, minimum 4.
REQ-002 The block SHALL have parameter GROUP, default 4: lookahead group width in bits; legal values are 2 and 4.
REQ-003 The block SHALL have parameter PIPE, default 2: number of register stages; legal range is 1 to WIDTH/GROUP.

Ports:
REQ-004 clk  in  1  the single clock; all state changes on the rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 in_valid  in  1  operand beat is present.
REQ-007 in_ready  out  1  block accepts an operand beat this cycle.
REQ-008 a  in  WIDTH  first operand.
REQ-009 b  in  WIDTH  second operand.
REQ-010 c_in  in  1  carry-in; acts as borrow-in when sub=1.
REQ-011 sub  in  1  0 = add, 1 = subtract.
REQ-012 out_valid  out  1  result beat is present.
REQ-013 out_ready  in  1  downstream accepts the result beat.
REQ-014 s  out  WIDTH  sum or difference.
REQ-015 c_out  out  1  carry-out of the MSB.
REQ-016 ovf  out  1  two's-complement overflow flag.

Function
REQ-017 Arithmetic SHALL be computed as follows: b_eff = b XOR {WIDTH{sub}}, cin_eff = c_in XOR sub, {c_out,s} = a + b_eff + cin_eff, evaluated modulo 2^(WIDTH+1).
REQ-018 Carries SHALL be formed by per-bit generate/propagate, group generate/propagate over GROUP bits, and a group-level lookahead; ripple across groups is forbidden.
REQ-019 ovf SHALL equal (a[MSB] == b_eff[MSB]) AND (s[MSB] != a[MSB]), using the unsaturated sum.
REQ-020 Group boundaries SHALL be split across PIPE stages as evenly as possible; the inter-stage carry and the upper operand bits SHALL be registered together.
REQ-021 Global advance enable SHALL be en = !out_valid || out_ready; in_ready = en, combinationally.
REQ-022 A beat SHALL be accepted when in_valid && in_ready.
REQ-023 When en=1, every stage SHALL shift one step; the stage-1 valid bit loads in_valid.
REQ-024 When en=0, all stages SHALL hold their contents and s, c_out and ovf SHALL remain stable.
REQ-025 Latency SHALL be exactly PIPE cycles from acceptance to out_valid when out_ready is held high.
REQ-026 Throughput SHALL be one beat per cycle with no stall; bubbles SHALL propagate as invalid stages.
REQ-027 A result SHALL leave the block when out_valid && out_ready; a new result may appear in the same edge.
REQ-028 When out_valid=0, s, c_out and ovf SHALL be 0.
REQ-029 Beat order SHALL be preserved; no beat SHALL be dropped or duplicated under any in_valid/out_ready pattern.

Reset
REQ-030 When rst=1 at a clock edge, all stage valid bits SHALL clear, and out_valid, s, c_out and ovf SHALL become 0.
REQ-031 Reset SHALL take priority over acceptance; a beat presented in the reset cycle SHALL be discarded.
REQ-032 Reset mid-operation SHALL flush all in-flight beats; in_ready SHALL be 1 in the first cycle after reset.

Configuration
REQ-033 With macro CLA_PIPE_SAT_EN defined, s SHALL saturate when ovf=1: s = 0x7F..F if a[MSB]=0, and s = 0x80..0 if a[MSB]=1.
REQ-034 With CLA_PIPE_SAT_EN defined, ovf and c_out SHALL report the unsaturated result.
REQ-035 Without CLA_PIPE_SAT_EN, s SHALL be the wrapped modulo result and the saturation logic SHALL be absent.

Verification
(Scenarios use WIDTH=16, GROUP=4, PIPE=2.)
REQ-036 a=0xFFFF, b=0x0001, c_in=0, sub=0 -> s=0x0000, c_out=1, ovf=0, out_valid exactly 2 cycles after acceptance.
REQ-037 a=0x7FFF, b=0x0001, sub=0 -> ovf=1; s=0x8000 without the macro, s=0x7FFF with CLA_PIPE_SAT_EN.
REQ-038 a=0x0005, b=0x0007, sub=1, c_in=0 -> s=0xFFFE, c_out=0, ovf=0; repeating with c_in=1 -> s=0xFFFD.
REQ-039 Stream of 8 beats with out_ready=0 for cycles 3-6 -> in_ready=0 while out_valid && !out_ready, all 8 results arrive in order, and outputs are stable during the stall.
REQ-040 rst asserted one cycle after 2 beats are accepted -> no out_valid is ever produced for those beats, and in_ready=1 the cycle after reset.
REQ-041 10,000 random beats with random in_valid/out_ready, repeated with PIPE=1 and PIPE=4 -> every result matches the reference a+b_eff+cin_eff model.
